// File: rtl/wb_regfile_pkg.sv
// Shared definitions for the writeback-stage register file.
// Holds the default data width, the hardwired-zero register index, the
// 5-bit register-index type, and the mapping from architectural index to
// storage slot.
package wb_regfile_pkg;

  localparam int DATA_W_DEF   = 64;
  localparam int ZERO_REG_DEF = 31;
  // One architectural register is hardwired to zero and has no storage.
  localparam int NUM_STORED   = 31;

  typedef logic [4:0] reg_idx_t;

  // Indices above the zero register shift down by one so that the 31 real
  // registers pack densely into slots 0..30. The zero register itself maps
  // to a slot too, but callers never write it and mask its reads.
  function automatic reg_idx_t slot_of(input reg_idx_t idx, input reg_idx_t zero_idx);
    reg_idx_t slot;
    if (idx > zero_idx) begin
      slot = idx - 5'd1;
    end else begin
      slot = idx;
    end
    return slot;
  endfunction

endpackage

// File: rtl/wb_regfile_if.sv
// Pipeline-side bus of the writeback register file.
// master: drives MEM/WB writeback controls/data and ID-stage read indices,
//         receives read data, writeback value and forwarding registers.
// slave : the register file itself (opposite directions).
interface wb_regfile_if
  import wb_regfile_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
);
  logic              MemtoReg_wb;
  logic              RegWrite_wb;
  reg_idx_t          Rd_wb;
  logic [DATA_W-1:0] dm_read_data_wb;
  logic [DATA_W-1:0] alu_result_wb;
  reg_idx_t          Rn_id;
  reg_idx_t          Rm_id;
  logic [DATA_W-1:0] rd_data1;
  logic [DATA_W-1:0] rd_data2;
  logic [DATA_W-1:0] wb_data;
  logic              fwd_valid;
  reg_idx_t          fwd_rd;
  logic [DATA_W-1:0] fwd_data;

  modport master (
    output MemtoReg_wb, RegWrite_wb, Rd_wb, dm_read_data_wb, alu_result_wb, Rn_id, Rm_id,
    input  rd_data1, rd_data2, wb_data, fwd_valid, fwd_rd, fwd_data
  );

  modport slave (
    input  MemtoReg_wb, RegWrite_wb, Rd_wb, dm_read_data_wb, alu_result_wb, Rn_id, Rm_id,
    output rd_data1, rd_data2, wb_data, fwd_valid, fwd_rd, fwd_data
  );

endinterface

// File: rtl/wb_regfile_regfile_array.sv
// Register storage: DEPTH x DATA_W flops, one synchronous write port and two
// asynchronous read ports. Addresses are storage slots, not architectural
// indices. Slots at or beyond DEPTH read as zero and ignore writes.
// Ports: clk, reset (async, active high, clears all slots), we/waddr/wdata,
//        raddr1/rdata1, raddr2/rdata2.
module regfile_array
  import wb_regfile_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = NUM_STORED
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              we,
  input  reg_idx_t          waddr,
  input  logic [DATA_W-1:0] wdata,
  input  reg_idx_t          raddr1,
  input  reg_idx_t          raddr2,
  output logic [DATA_W-1:0] rdata1,
  output logic [DATA_W-1:0] rdata2
);

  logic [DATA_W-1:0] mem_r [DEPTH];

  // Storage update: async clear, single write port.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= '0;
      end
    end else if (we && (int'(waddr) < DEPTH)) begin
      mem_r[waddr] <= wdata;
    end
  end

  // Asynchronous read ports with out-of-range slots reading zero.
  always_comb begin
    rdata1 = '0;
    rdata2 = '0;
    if (int'(raddr1) < DEPTH) begin
      rdata1 = mem_r[raddr1];
    end else begin
      rdata1 = '0;
    end
    if (int'(raddr2) < DEPTH) begin
      rdata2 = mem_r[raddr2];
    end else begin
      rdata2 = '0;
    end
  end

endmodule

// File: rtl/wb_regfile.sv
// Writeback-stage register file with write-through bypass and a one-cycle
// forwarding register.
// Ports: clk, reset (async, active high), bus (wb_regfile_if.slave) carrying
//        writeback controls/data, two ID-stage read indices, read data,
//        combinational wb_data and registered fwd_valid/fwd_rd/fwd_data.
module wb_regfile
  import wb_regfile_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int ZERO_REG = ZERO_REG_DEF
) (
  input  logic         clk,
  input  logic         reset,
  wb_regfile_if.slave  bus
);

  localparam reg_idx_t ZERO_IDX = reg_idx_t'(ZERO_REG);

  logic [DATA_W-1:0] wb_data_s;
  logic              wr_eff_s;
  logic [DATA_W-1:0] arr_rd1_s;
  logic [DATA_W-1:0] arr_rd2_s;
  logic [DATA_W-1:0] rd1_s;
  logic [DATA_W-1:0] rd2_s;
  logic              fwd_valid_r;
  reg_idx_t          fwd_rd_r;
  logic [DATA_W-1:0] fwd_data_r;

  // Writeback source select and effective-write qualification.
  always_comb begin
    wb_data_s = '0;
    if (bus.MemtoReg_wb) begin
      wb_data_s = bus.dm_read_data_wb;
    end else begin
      wb_data_s = bus.alu_result_wb;
    end
    wr_eff_s = bus.RegWrite_wb && (bus.Rd_wb != ZERO_IDX);
  end

  // The array's own async reset already blocks writes while reset is high;
  // gating we as well keeps the intent explicit at this level.
  regfile_array #(
    .DATA_W (DATA_W),
    .DEPTH  (NUM_STORED)
  ) u_array (
    .clk    (clk),
    .reset  (reset),
    .we     (wr_eff_s && !reset),
    .waddr  (slot_of(bus.Rd_wb, ZERO_IDX)),
    .wdata  (wb_data_s),
    .raddr1 (slot_of(bus.Rn_id, ZERO_IDX)),
    .raddr2 (slot_of(bus.Rm_id, ZERO_IDX)),
    .rdata1 (arr_rd1_s),
    .rdata2 (arr_rd2_s)
  );

  // Read ports: zero register first, then write-through bypass, then storage.
  // Bypass is purely combinational and stays live during reset.
  always_comb begin
    rd1_s = '0;
    rd2_s = '0;
    if (bus.Rn_id == ZERO_IDX) begin
      rd1_s = '0;
    end else if (wr_eff_s && (bus.Rn_id == bus.Rd_wb)) begin
      rd1_s = wb_data_s;
    end else begin
      rd1_s = arr_rd1_s;
    end
    if (bus.Rm_id == ZERO_IDX) begin
      rd2_s = '0;
    end else if (wr_eff_s && (bus.Rm_id == bus.Rd_wb)) begin
      rd2_s = wb_data_s;
    end else begin
      rd2_s = arr_rd2_s;
    end
  end

  // Forwarding register: captures every cycle, valid only for real writes.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fwd_valid_r <= 1'b0;
      fwd_rd_r    <= 5'd0;
      fwd_data_r  <= '0;
    end else begin
      fwd_valid_r <= wr_eff_s;
      fwd_rd_r    <= bus.Rd_wb;
      fwd_data_r  <= wb_data_s;
    end
  end

  assign bus.rd_data1  = rd1_s;
  assign bus.rd_data2  = rd2_s;
  assign bus.wb_data   = wb_data_s;
  assign bus.fwd_valid = fwd_valid_r;
  assign bus.fwd_rd    = fwd_rd_r;
  assign bus.fwd_data  = fwd_data_r;

endmodule

// File: tb/tb_wb_regfile.sv
// Scoreboard bench for wb_regfile: stimulus drives one vector per cycle
// (#1 after the rising edge) and queues the expected outputs; a monitor
// pops and compares them on the following falling edge.
module tb_wb_regfile;

  localparam int S_RD1 = 0;
  localparam int S_RD2 = 1;
  localparam int S_WB  = 2;
  localparam int S_FV  = 3;
  localparam int S_FRD = 4;
  localparam int S_FD  = 5;

  typedef struct {
    string       name;
    int          sel;
    logic [63:0] exp;
  } chk_t;

  logic clk;
  logic reset;
  chk_t q[$];
  int   n_total;
  int   n_pass;

  wb_regfile_if #(.DATA_W(64)) bus ();

  wb_regfile #(
    .DATA_W   (64),
    .ZERO_REG (31)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Watchdog: never hang.
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [63:0] actual(input int sel);
    logic [63:0] v;
    case (sel)
      S_RD1:   v = bus.rd_data1;
      S_RD2:   v = bus.rd_data2;
      S_WB:    v = bus.wb_data;
      S_FV:    v = {63'd0, bus.fwd_valid};
      S_FRD:   v = {59'd0, bus.fwd_rd};
      S_FD:    v = bus.fwd_data;
      default: v = 64'hx;
    endcase
    return v;
  endfunction

  // Monitor: compare all expectations queued during the current cycle.
  initial begin
    n_total = 0;
    n_pass  = 0;
    forever begin
      @(negedge clk);
      while (q.size() > 0) begin
        chk_t c;
        logic [63:0] a;
        c = q.pop_front();
        a = actual(c.sel);
        n_total++;
        if (a === c.exp) begin
          n_pass++;
        end else begin
          $display("FAIL %s: got %h expected %h", c.name, a, c.exp);
        end
      end
    end
  end

  task automatic chk(input string n, input int sel, input logic [63:0] v);
    chk_t c;
    c.name = n;
    c.sel  = sel;
    c.exp  = v;
    q.push_back(c);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic rw, input logic mtr, input logic [4:0] rd,
                       input logic [63:0] dm, input logic [63:0] alu,
                       input logic [4:0] rn, input logic [4:0] rm);
    bus.RegWrite_wb     = rw;
    bus.MemtoReg_wb     = mtr;
    bus.Rd_wb           = rd;
    bus.dm_read_data_wb = dm;
    bus.alu_result_wb   = alu;
    bus.Rn_id           = rn;
    bus.Rm_id           = rm;
  endtask

  initial begin
    reset = 1'b1;
    drive(1'b0, 1'b0, 5'd0, 64'd0, 64'd0, 5'd0, 5'd0);
    step();
    chk("in_reset_rd1", S_RD1, 64'd0);
    chk("in_reset_fv", S_FV, 64'd0);
    step();
    reset = 1'b0;

    // All 32 indices read zero after reset.
    for (int i = 0; i < 16; i++) begin
      drive(1'b0, 1'b0, 5'd0, 64'd0, 64'd0, 5'(2 * i), 5'(2 * i + 1));
      chk($sformatf("rst_rd1_r%0d", 2 * i), S_RD1, 64'd0);
      chk($sformatf("rst_rd2_r%0d", 2 * i + 1), S_RD2, 64'd0);
      chk("rst_fv", S_FV, 64'd0);
      step();
    end

    // Bypass then stored value, plus forwarding register.
    drive(1'b1, 1'b0, 5'd5, 64'd0, 64'hDEAD, 5'd5, 5'd6);
    chk("byp_rd1", S_RD1, 64'hDEAD);
    chk("byp_rd2_other", S_RD2, 64'd0);
    chk("byp_wb", S_WB, 64'hDEAD);
    step();
    drive(1'b0, 1'b0, 5'd0, 64'd0, 64'd0, 5'd5, 5'd0);
    chk("stored_rd1", S_RD1, 64'hDEAD);
    chk("fwd_valid_5", S_FV, 64'd1);
    chk("fwd_rd_5", S_FRD, 64'd5);
    chk("fwd_data_5", S_FD, 64'hDEAD);
    step();

    // Writes to the zero register are discarded.
    drive(1'b1, 1'b0, 5'd31, 64'd0, 64'h1234, 5'd31, 5'd31);
    chk("zero_rd1", S_RD1, 64'd0);
    chk("zero_rd2", S_RD2, 64'd0);
    chk("zero_wb", S_WB, 64'h1234);
    step();
    drive(1'b0, 1'b0, 5'd0, 64'd0, 64'd0, 5'd5, 5'd31);
    chk("zero_fv", S_FV, 64'd0);
    chk("zero_frd", S_FRD, 64'd31);
    chk("zero_fdata", S_FD, 64'h1234);
    chk("zero_rd2_after", S_RD2, 64'd0);
    chk("keep_r5", S_RD1, 64'hDEAD);
    step();

    // Load data selected for writeback.
    drive(1'b1, 1'b1, 5'd7, 64'hCAFE, 64'hBEEF, 5'd8, 5'd5);
    chk("mem_wb", S_WB, 64'hCAFE);
    chk("mem_rd2_r5", S_RD2, 64'hDEAD);
    step();
    drive(1'b0, 1'b0, 5'd0, 64'd0, 64'd0, 5'd7, 5'd8);
    chk("mem_r7", S_RD1, 64'hCAFE);
    chk("mem_r8", S_RD2, 64'd0);
    chk("mem_fdata", S_FD, 64'hCAFE);
    chk("mem_frd", S_FRD, 64'd7);
    step();

    // Dual-port bypass of the same register.
    drive(1'b1, 1'b0, 5'd9, 64'd0, 64'h55, 5'd9, 5'd9);
    chk("dual_rd1", S_RD1, 64'h55);
    chk("dual_rd2", S_RD2, 64'h55);
    step();
    drive(1'b1, 1'b0, 5'd0, 64'd0, 64'h77, 5'd9, 5'd0);
    chk("r9_stored", S_RD1, 64'h55);
    chk("r0_bypass", S_RD2, 64'h77);
    step();
    drive(1'b1, 1'b0, 5'd30, 64'd0, 64'hA5A5_0000_0000_0030, 5'd0, 5'd29);
    chk("r0_stored", S_RD1, 64'h77);
    chk("r29_empty", S_RD2, 64'd0);
    step();
    drive(1'b0, 1'b0, 5'd0, 64'd0, 64'd0, 5'd30, 5'd9);
    chk("r30_stored", S_RD1, 64'hA5A5_0000_0000_0030);
    chk("r9_again", S_RD2, 64'h55);
    step();

    // Back-to-back writes to register 3.
    drive(1'b1, 1'b0, 5'd3, 64'd0, 64'h1, 5'd3, 5'd0);
    chk("b2b_first", S_RD1, 64'h1);
    step();
    drive(1'b1, 1'b0, 5'd3, 64'd0, 64'h2, 5'd3, 5'd3);
    chk("b2b_second", S_RD2, 64'h2);
    chk("b2b_fdata1", S_FD, 64'h1);
    step();
    drive(1'b0, 1'b0, 5'd3, 64'd0, 64'h2, 5'd3, 5'd0);
    chk("b2b_stored", S_RD1, 64'h2);
    chk("b2b_fdata2", S_FD, 64'h2);
    step();

    // Async reset mid-cycle with a write to r3 pending.
    drive(1'b1, 1'b0, 5'd3, 64'd0, 64'h3, 5'd3, 5'd5);
    #1;
    reset = 1'b1;
    chk("rst_bypass_live", S_RD1, 64'h3);
    chk("rst_r5_cleared", S_RD2, 64'd0);
    chk("rst_fv", S_FV, 64'd0);
    chk("rst_frd", S_FRD, 64'd0);
    chk("rst_fdata", S_FD, 64'd0);
    step();
    drive(1'b1, 1'b0, 5'd3, 64'd0, 64'h4, 5'd10, 5'd11);
    chk("rst_hold_fv", S_FV, 64'd0);
    chk("rst_hold_frd", S_FRD, 64'd0);
    chk("rst_hold_fdata", S_FD, 64'd0);
    step();
    drive(1'b0, 1'b0, 5'd0, 64'd0, 64'd0, 5'd3, 5'd9);
    chk("rst_r3_zero", S_RD1, 64'd0);
    chk("rst_r9_zero", S_RD2, 64'd0);
    step();

    // First write after deassertion lands on the first edge.
    reset = 1'b0;
    drive(1'b1, 1'b0, 5'd3, 64'd0, 64'h6, 5'd3, 5'd30);
    chk("post_byp", S_RD1, 64'h6);
    chk("post_r30_zero", S_RD2, 64'd0);
    step();
    drive(1'b0, 1'b0, 5'd0, 64'd0, 64'd0, 5'd3, 5'd0);
    chk("post_r3", S_RD1, 64'h6);
    chk("post_fv", S_FV, 64'd1);
    chk("post_frd", S_FRD, 64'd3);
    chk("post_fdata", S_FD, 64'h6);
    step();

    @(negedge clk);
    #1;
    n_total++;
    if (q.size() == 0) begin
      n_pass++;
    end else begin
      $display("FAIL queue_drained: got %0d pending expected 0", q.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/wb_regfile.md
WB_REGFILE -- requirements
Module: wb_regfile

Interface
REQ-001 Parameter DATA_W, default 64, register and data width in bits.
REQ-002 Parameter ZERO_REG, default 31, index of the hardwired-zero register.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 MemtoReg_wb  input  1  1 selects load data, 0 selects ALU result for writeback.
REQ-006 RegWrite_wb  input  1  writeback enable from MEM/WB register.
REQ-007 Rd_wb  input  5  destination register index.
REQ-008 dm_read_data_wb  input  DATA_W  load data from MEM/WB register.
REQ-009 alu_result_wb  input  DATA_W  ALU result from MEM/WB register.
REQ-010 Rn_id  input  5  read port 1 index (ID stage).
REQ-011 Rm_id  input  5  read port 2 index (ID stage).
REQ-012 rd_data1  output  DATA_W  read port 1 data.
REQ-013 rd_data2  output  DATA_W  read port 2 data.
REQ-014 wb_data  output  DATA_W  selected writeback value, combinational.
REQ-015 fwd_valid  output  1  registered: previous cycle performed a real write.
REQ-016 fwd_rd  output  5  registered destination of previous cycle's write.
REQ-017 fwd_data  output  DATA_W  registered data of previous cycle's write.

Function
REQ-018 wb_data SHALL equal dm_read_data_wb when MemtoReg_wb=1, else alu_result_wb, with zero latency.
REQ-019 A write is effective when RegWrite_wb=1 and Rd_wb!=ZERO_REG; it SHALL update register Rd_wb with wb_data on the next rising edge of clk.
REQ-020 Writes to ZERO_REG SHALL be discarded; reads of ZERO_REG SHALL return 0 in all cases.
REQ-021 Read ports SHALL be combinational: rd_dataN reflects the stored register value in the same cycle the index is applied.
REQ-022 Write-through bypass: when an effective write targets the index on a read port in the same cycle, that port SHALL return wb_data, not the stored value.
REQ-023 Both read ports SHALL bypass independently; Rn_id=Rm_id=Rd_wb returns wb_data on both.
REQ-024 On each rising edge, fwd_valid SHALL load the effective-write condition, fwd_rd SHALL load Rd_wb and fwd_data SHALL load wb_data; a non-effective cycle loads fwd_valid=0 and still loads fwd_rd/fwd_data.
REQ-025 Back-to-back writes to the same register SHALL leave the later value stored; no write is lost or reordered.
REQ-026 Indices are 5 bits; all 32 values are legal, no wrap or range error exists.

Reset
REQ-027 Asserting reset SHALL immediately, without a clock edge, clear all 32 registers, fwd_valid, fwd_rd and fwd_data to 0.
REQ-028 While reset is high, writes SHALL be blocked; rd_data1/rd_data2 SHALL read 0 except via REQ-022 bypass, which remains active as combinational logic.
REQ-029 Reset asserted mid-operation SHALL discard any write pending for that edge; the first write after deassertion takes effect on the first rising edge with reset low.

Structure
REQ-030 DATA_W default, ZERO_REG, and the 5-bit register-index typedef SHALL live in the shared CPU package.
REQ-031 Storage SHALL be a sub-module regfile_array (31 x DATA_W flops, one write port, two async read ports); muxing, bypass and forwarding registers stay in wb_regfile.

Verification
REQ-032 Reset then read all 32 indices -> every rd_data = 0, fwd_valid=0.
REQ-033 RegWrite=1, Rd=5, MemtoReg=0, alu=0xDEAD, Rn=5 same cycle -> rd_data1=0xDEAD (bypass); next cycle, RegWrite=0 -> rd_data1=0xDEAD (stored), fwd_valid=1, fwd_rd=5, fwd_data=0xDEAD.
REQ-034 RegWrite=1, Rd=31, alu=0x1234, Rn=Rm=31 -> rd_data1=rd_data2=0, next cycle fwd_valid=0.
REQ-035 MemtoReg=1, dm=0xCAFE, alu=0xBEEF, Rd=7 -> wb_data=0xCAFE, register 7 = 0xCAFE after edge.
REQ-036 Write Rd=3 value 0x1 then 0x2 on consecutive edges -> register 3 = 0x2; assert reset asynchronously mid-cycle with Rd=3 value 0x3 pending -> register 3 = 0, fwd_* = 0 without a clock edge.
